// File: rtl/vote_pkg.sv
// Shared definitions for the vote report read-out: winner codes, frame constants,
// serialiser and report FSM encodings, and the winner decision helper.
package vote_pkg;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_C1   = 2'd1;
    localparam logic [1:0] WIN_C2   = 2'd2;
    localparam logic [1:0] WIN_TIE  = 2'd3;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 6;
    localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic {
        RPT_IDLE = 1'b0,
        RPT_SEND = 1'b1
    } rpt_state_e;

    // The null counter never takes part in the decision.
    function automatic logic [1:0] winner_code(input logic [7:0] c1, input logic [7:0] c2);
        logic [1:0] code;
        if ((c1 == 8'd0) && (c2 == 8'd0)) begin
            code = WIN_NONE;
        end else if (c1 > c2) begin
            code = WIN_C1;
        end else if (c2 > c1) begin
            code = WIN_C2;
        end else begin
            code = WIN_TIE;
        end
        return code;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A start accepted in the last stop-bit cycle chains the
// next byte directly, so consecutive bytes leave no idle gap on the line.
module uart_tx_byte
    import vote_pkg::*;
#(
    parameter int BIT_CYCLES = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int             CW      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(BIT_CYCLES - 1);

    tx_state_e     state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    data_r;
    logic          tx_r;
    logic          bit_end_s;

    // Bit-period end and acceptance window for the next byte.
    always_comb begin
        bit_end_s = (cnt_r == CNT_MAX);
        ready     = (state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_end_s);
    end

    assign tx = tx_r;

    // Serialiser state, baud counter and line driver.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            data_r    <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (start) begin
                        state_r <= ST_START;
                        data_r  <= data;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                        tx_r      <= data_r[0];
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= data_r[bit_idx_r + 3'd1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        if (start) begin
                            state_r <= ST_START;
                            data_r  <= data;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/vote_report_tx.sv
// Vote report transmitter: snapshots the three counters on a request, decides the
// winner and sends the 6-byte result frame (header, counts, winner, checksum).
module vote_report_tx
    import vote_pkg::*;
#(
    parameter int CLK_FREQ = 1000000,
    parameter int BAUD     = 9600,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             report_req,
    input  logic [CNT_W-1:0] ctr1,
    input  logic [CNT_W-1:0] ctr2,
    input  logic [CNT_W-1:0] ctr3,
    output logic             tx,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;

    rpt_state_e rpt_state_r;
    logic       req_q_r;
    logic       arm_r;
    logic [2:0] byte_idx_r;
    logic [7:0] c1_r, c2_r, c3_r;
    logic [7:0] csum_r;
    logic [1:0] winner_r;
    logic       busy_r;
    logic       done_r;

    logic [7:0] c1_s, c2_s, c3_s;
    logic       req_s;
    logic       start_s;
    logic       last_s;
    logic [7:0] data_s;
    logic [7:0] next_byte_s;
    logic       ready_s;

    // Request edge detection and next-byte selection toward the serialiser.
    always_comb begin
        c1_s  = 8'(ctr1);
        c2_s  = 8'(ctr2);
        c3_s  = 8'(ctr3);
        // arm_r keeps a request held across reset from counting as a fresh edge.
        req_s = report_req && !req_q_r && arm_r && (rpt_state_r == RPT_IDLE);
        case (byte_idx_r)
            3'd0:    next_byte_s = c1_r;
            3'd1:    next_byte_s = c2_r;
            3'd2:    next_byte_s = c3_r;
            3'd3:    next_byte_s = {6'd0, winner_r};
            3'd4:    next_byte_s = csum_r;
            default: next_byte_s = FRAME_HDR;
        endcase
        start_s = 1'b0;
        last_s  = 1'b0;
        data_s  = FRAME_HDR;
        case (rpt_state_r)
            RPT_IDLE: begin
                start_s = req_s;
                data_s  = FRAME_HDR;
            end
            RPT_SEND: begin
                if (ready_s) begin
                    if (byte_idx_r == LAST_BYTE) begin
                        last_s = 1'b1;
                    end else begin
                        start_s = 1'b1;
                        data_s  = next_byte_s;
                    end
                end else begin
                    start_s = 1'b0;
                end
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Report sequencing: snapshot, winner, checksum accumulation and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rpt_state_r <= RPT_IDLE;
            req_q_r     <= 1'b0;
            arm_r       <= 1'b0;
            byte_idx_r  <= 3'd0;
            c1_r        <= 8'd0;
            c2_r        <= 8'd0;
            c3_r        <= 8'd0;
            csum_r      <= 8'd0;
            winner_r    <= WIN_NONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            req_q_r <= report_req;
            done_r  <= 1'b0;
            if (!report_req) begin
                arm_r <= 1'b1;
            end
            case (rpt_state_r)
                RPT_IDLE: begin
                    if (req_s) begin
                        c1_r        <= c1_s;
                        c2_r        <= c2_s;
                        c3_r        <= c3_s;
                        winner_r    <= winner_code(c1_s, c2_s);
                        csum_r      <= FRAME_HDR;
                        byte_idx_r  <= 3'd0;
                        busy_r      <= 1'b1;
                        rpt_state_r <= RPT_SEND;
                    end
                end
                RPT_SEND: begin
                    if (last_s) begin
                        rpt_state_r <= RPT_IDLE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                    end else if (start_s) begin
                        byte_idx_r <= byte_idx_r + 3'd1;
                        // The checksum byte itself is not summed.
                        if (byte_idx_r != 3'd4) begin
                            csum_r <= csum_r + data_s;
                        end
                    end
                end
                default: begin
                    rpt_state_r <= RPT_IDLE;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_uart (
        .clk  (clk),
        .rst  (rst),
        .start(start_s),
        .data (data_s),
        .tx   (tx),
        .ready(ready_s)
    );

    assign busy   = busy_r;
    assign done   = done_r;
    assign winner = winner_r;

endmodule

// File: tb/tb_vote_report_tx.sv
// Directed bench for vote_report_tx: default instance (3-bit counters, 104-cycle bits)
// and a fast 8-bit instance (8-cycle bits), frames decoded and checked cycle by cycle.
module tb_vote_report_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b;
    logic [2:0] c1_a, c2_a, c3_a;
    logic [7:0] c1_b, c2_b, c3_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;
    logic [1:0] win_a, win_b;

    logic       sel;
    logic       tx_m, busy_m, done_m;
    logic [1:0] win_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign tx_m   = sel ? tx_b   : tx_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign done_m = sel ? done_b : done_a;
    assign win_m  = sel ? win_b  : win_a;

    vote_report_tx dut_a (
        .clk(clk), .rst(rst), .report_req(req_a),
        .ctr1(c1_a), .ctr2(c2_a), .ctr3(c3_a),
        .tx(tx_a), .busy(busy_a), .done(done_a), .winner(win_a)
    );

    vote_report_tx #(.CLK_FREQ(800), .BAUD(100), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .report_req(req_b),
        .ctr1(c1_b), .ctr2(c2_b), .ctr3(c3_b),
        .tx(tx_b), .busy(busy_b), .done(done_b), .winner(win_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v);
        if (sel) req_b = v;
        else     req_a = v;
    endtask

    // mode 0: single pulse; 1: held high with glitches and ctr1 change; 2: reset in byte 2.
    task automatic run_frame(input string name, input logic [47:0] frame, input int bc,
                             input int mode, input logic [1:0] exp_win);
        logic [7:0] rx [6];
        int         bad;
        bit         aborted;
        int         b, k, bi;
        logic [7:0] eb;
        logic       ebit;
        bad     = 0;
        aborted = 1'b0;
        for (int i = 0; i < 6; i++) rx[i] = 8'h00;
        set_req(1'b1);
        for (int t = 0; t < 60 * bc; t++) begin
            @(negedge clk);
            b  = t / bc;
            k  = b / 10;
            bi = b % 10;
            eb = frame[8 * (5 - k) +: 8];
            if (bi == 0)      ebit = 1'b0;
            else if (bi == 9) ebit = 1'b1;
            else              ebit = eb[bi - 1];
            if ((tx_m !== ebit) || (busy_m !== 1'b1) || (done_m !== 1'b0)) bad++;
            if ((t % bc == bc / 2) && (bi >= 1) && (bi <= 8)) rx[k][bi - 1] = tx_m;
            if (t == 0) begin
                check({name, " first tx"}, 32'(tx_m), 32'd0);
                check({name, " first busy"}, 32'(busy_m), 32'd1);
                check({name, " winner"}, 32'(win_m), 32'(exp_win));
                if (mode != 1) set_req(1'b0);
            end
            if (mode == 1) begin
                if (t == 1000) c1_a = 3'd7;
                if (t == 2000 || t == 3000) req_a = 1'b0;
                if (t == 2010 || t == 3003) req_a = 1'b1;
            end
            if ((mode == 2) && (t == 22 * bc + 5)) begin
                check({name, " pre-reset bits"}, 32'(bad), 32'd0);
                rst = 1'b0;
                @(negedge clk);
                check({name, " reset tx"}, 32'(tx_m), 32'd1);
                check({name, " reset busy"}, 32'(busy_m), 32'd0);
                check({name, " reset done"}, 32'(done_m), 32'd0);
                rst = 1'b1;
                @(negedge clk);
                check({name, " post-reset done"}, 32'(done_m), 32'd0);
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            check({name, " bit-exact waveform errors"}, 32'(bad), 32'd0);
            for (int i = 0; i < 6; i++)
                check($sformatf("%s byte%0d", name, i), 32'(rx[i]), 32'(frame[8 * (5 - i) +: 8]));
            @(negedge clk);
            check({name, " done pulse"}, 32'(done_m), 32'd1);
            check({name, " end busy"}, 32'(busy_m), 32'd0);
            check({name, " end tx"}, 32'(tx_m), 32'd1);
            check({name, " winner hold"}, 32'(win_m), 32'(exp_win));
            @(negedge clk);
            check({name, " done single"}, 32'(done_m), 32'd0);
        end
    endtask

    initial begin
        int busy_seen;
        sel   = 1'b0;
        rst   = 1'b0;
        req_a = 1'b1;
        req_b = 1'b0;
        c1_a = 3'd0; c2_a = 3'd0; c3_a = 3'd0;
        c1_b = 8'd0; c2_b = 8'd0; c3_b = 8'd0;

        // 1: reset with a request held high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst tx", 32'(tx_a), 32'd1);
            check("rst busy", 32'(busy_a), 32'd0);
            check("rst done", 32'(done_a), 32'd0);
            check("rst winner", 32'(win_a), 32'd0);
        end
        rst = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || tx_a !== 1'b1) busy_seen++;
        end
        check("held req after reset idle", 32'(busy_seen), 32'd0);
        req_a = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // 2: candidate 1 wins
        c1_a = 3'd3; c2_a = 3'd1; c3_a = 3'd2;
        run_frame("c1win", 48'hA5_03_01_02_01_AC, 104, 0, 2'd1);

        // 3: tie, then all zero (request fired from the done cycle onward)
        c1_a = 3'd2; c2_a = 3'd2; c3_a = 3'd0;
        run_frame("tie", 48'hA5_02_02_00_03_AC, 104, 0, 2'd3);
        c1_a = 3'd0; c2_a = 3'd0; c3_a = 3'd0;
        run_frame("zero", 48'hA5_00_00_00_00_A5, 104, 0, 2'd0);

        // 4: held request, glitches and counter change mid-frame
        c1_a = 3'd3; c2_a = 3'd1; c3_a = 3'd2;
        run_frame("hold", 48'hA5_03_01_02_01_AC, 104, 1, 2'd1);
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b0) busy_seen++;
        end
        check("hold no second frame", 32'(busy_seen), 32'd0);
        req_a = 1'b0;
        @(negedge clk);

        // 5: reset during byte 2 data bits, then a full frame
        c1_a = 3'd2; c2_a = 3'd2; c3_a = 3'd0;
        run_frame("abort", 48'hA5_02_02_00_03_AC, 104, 2, 2'd3);
        check("abort winner cleared", 32'(win_a), 32'd0);
        c1_a = 3'd1; c2_a = 3'd0; c3_a = 3'd0;
        run_frame("after-abort", 48'hA5_01_00_00_01_A7, 104, 0, 2'd1);

        // 6: 8-bit counters at 8 cycles per bit
        sel  = 1'b1;
        c1_b = 8'hFF; c2_b = 8'hFF; c3_b = 8'hFF;
        run_frame("wide", 48'hA5_FF_FF_FF_03_A5, 8, 0, 2'd3);
        check("wide idle A", 32'(busy_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vote_report_tx.md
Name: vote_report_tx

Overview:
- Read-out end of the voting machine.
- On a report request, snapshots the three vote counters (candidate 1, candidate 2, null) and computes a winner code.
- Serialises a fixed 6-byte result frame on a UART-style 8N1 line to an external display or logger.
- Sits beside the vote-capture block and consumes its ctr1/ctr2/ctr3 outputs.

Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD, 9600: serial bit rate. BIT_CYCLES = CLK_FREQ/BAUD, integer-truncated; 104 at defaults.
- CNT_W, 3: width of each vote counter input. Legal range 1..8.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, synchronous and active-low.
- report_req, input, 1: request a report; acted on at its rising edge.
- ctr1, input, CNT_W: candidate 1 vote count.
- ctr2, input, CNT_W: candidate 2 vote count.
- ctr3, input, CNT_W: null vote count.
- tx, output, 1: serial output; idle high.
- busy, output, 1: frame in progress.
- done, output, 1: one-cycle pulse at frame completion.
- winner, output, 2: winner code of the last snapshot.

Behaviour:
- Reset: rst==0 at a clk edge forces the following, regardless of state:
  - tx=1, busy=0, done=0, winner=0;
  - FSM to IDLE; all counters and indices 0;
  - req_q=0, the registered copy of report_req.
- Request detection: a request is (report_req==1 && req_q==0) while in IDLE.
  - Requests while busy are ignored, not queued.
  - A held-high report_req produces exactly one frame.
- Snapshot: in the request cycle N, register ctr1/ctr2/ctr3 zero-extended to 8 bits, plus the winner code.
  - Counter changes after cycle N do not affect the frame.
- Winner code:
  - 0 if ctr1==0 and ctr2==0;
  - 1 if ctr1>ctr2;
  - 2 if ctr2>ctr1;
  - 3 if ctr1==ctr2 and both are nonzero.
  - ctr3 never wins.
  - The winner output updates at cycle N+1 and holds until the next snapshot.
- Frame bytes, in order:
  - 0xA5 header;
  - c1, c2, c3;
  - winner code, zero-extended;
  - checksum = (sum of the previous 5 bytes) mod 256.
- Line format per byte:
  - start bit 0, 8 data bits LSB first, stop bit 1;
  - each bit held exactly BIT_CYCLES cycles;
  - no idle gap between bytes.
- FSM states and transitions:
  - IDLE -> START on a request.
  - START -> DATA after BIT_CYCLES cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START (next byte) if byte_idx<5, else back to IDLE.
- Timing: tx=0 and busy=1 from cycle N+1. busy stays high for exactly 60*BIT_CYCLES cycles (6240 at defaults).
- Completion: in the first cycle with busy==0 after a frame:
  - done=1 for one cycle;
  - tx=1.
- Back-to-back: a new request is accepted from the done cycle onward, provided a fresh rising edge is seen.
- Reset mid-frame: on the next cycle tx=1 and busy=0. No done pulse is generated and the partial frame is abandoned.
- Widths:
  - baud counter ceil(log2(BIT_CYCLES)) bits;
  - bit index 3 bits;
  - byte index 3 bits;
  - checksum is an 8-bit wrapping accumulator.

Decomposition:
- Shared package vote_pkg holds:
  - winner codes WIN_NONE=0, WIN_C1=1, WIN_C2=2, WIN_TIE=3;
  - FRAME_HDR=8'hA5, FRAME_LEN=6;
  - the report FSM state encoding.
- One sub-module, uart_tx_byte:
  - an 8N1 serialiser parameterised by BIT_CYCLES;
  - inputs start and data[7:0]; outputs tx and ready.
  - vote_report_tx sequences the six frame bytes through it and owns the snapshot, winner and checksum logic.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with report_req=1 -> tx=1, busy=0, done=0, winner=0 throughout; no frame after release until report_req falls and rises again.
2. ctr1=3, ctr2=1, ctr3=2, pulse report_req -> frame A5 03 01 02 01 AC; winner=1; busy high for 6240 cycles; a single done pulse; each bit 104 cycles wide.
3. ctr1=2, ctr2=2, ctr3=0 -> winner=3; frame A5 02 02 00 03 AC. Then all counts 0 -> winner=0; frame A5 00 00 00 00 A5.
4. Hold report_req high for the whole frame, add extra pulses mid-frame, and change ctr1 from 3 to 7 mid-frame -> exactly one frame, carrying the snapshot value 03; no second frame until a new rising edge after done.
5. Assert rst=0 during byte 2's data bits -> next cycle tx=1, busy=0, no done pulse; then a request with ctr=1,0,0 -> full frame A5 01 00 00 01 A7.
6. CNT_W=8, CLK_FREQ=800, BAUD=100, ctr1=ctr2=ctr3=8'hFF -> winner=3; checksum (A5+FF+FF+FF+03) mod 256 = A5; BIT_CYCLES=8, busy for 480 cycles.
